// File: rtl/wishbone_interconnect_n.sv
// Single-master, N-slave Wishbone classic interconnect. It decodes the slave from the top address byte,
// runs a timeout watchdog, returns err for unmapped addresses, and holds a local interrupt status/mask block.
module wishbone_interconnect_n #(
  parameter int         NUM_SLAVES     = 4,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] INT_ADDR       = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_we_i,
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  input  logic [3:0]                 m_sel_i,
  input  logic [31:0]                m_adr_i,
  input  logic [31:0]                m_dat_i,
  output logic [31:0]                m_dat_o,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  output logic                       m_int_o,
  output logic [NUM_SLAVES-1:0]      s_we_o,
  output logic [NUM_SLAVES-1:0]      s_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  output logic [4*NUM_SLAVES-1:0]    s_sel_o,
  output logic [32*NUM_SLAVES-1:0]   s_adr_o,
  output logic [32*NUM_SLAVES-1:0]   s_dat_o,
  input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,
  input  logic [NUM_SLAVES-1:0]      s_int_i
);

  // Only the low 32 interrupt lines are visible through the 32-bit data bus.
  localparam int          LW           = (NUM_SLAVES < 32) ? NUM_SLAVES : 32;
  localparam logic [8:0]  NUM_SLAVES_W = 9'(NUM_SLAVES);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, LOCAL, DONE} state_t;

  state_t                state_reg, state_next;
  logic [7:0]            cur_reg, cur_next;
  logic [15:0]           cnt_reg, cnt_next;
  logic [31:0]           dat_reg, dat_next;
  logic                  ack_reg, ack_next;
  logic                  err_reg, err_next;
  logic                  int_reg, int_next;
  logic [NUM_SLAVES-1:0] mask_reg, mask_next;

  logic [NUM_SLAVES-1:0] hit;
  logic [31:0]           s_rdat_gated [NUM_SLAVES];
  logic [31:0]           slave_rdat;
  logic                  slave_ack;
  logic [7:0]            req_sel;
  logic [23:0]           offset;
  logic [31:0]           int_raw_w;
  logic [31:0]           int_mask_w;

  assign req_sel    = m_adr_i[31:24];
  assign offset     = m_adr_i[23:0];
  assign int_raw_w  = 32'(s_int_i[LW-1:0]);
  assign int_mask_w = 32'(mask_reg[LW-1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign hit[gi]                = (state_reg == ACTIVE) && (cur_reg == 8'(gi));
      assign s_we_o[gi]             = hit[gi] & m_we_i;
      assign s_cyc_o[gi]            = hit[gi] & m_cyc_i;
      assign s_stb_o[gi]            = hit[gi] & m_stb_i;
      assign s_sel_o[4*gi +: 4]     = hit[gi] ? m_sel_i : 4'h0;
      assign s_adr_o[32*gi +: 32]   = hit[gi] ? {8'h00, m_adr_i[23:0]} : 32'h0;
      assign s_dat_o[32*gi +: 32]   = hit[gi] ? m_dat_i : 32'h0;
      assign s_rdat_gated[gi]       = hit[gi] ? s_dat_i[32*gi +: 32] : 32'h0;
    end
  endgenerate

  // The one-hot hit vector turns the read mux into an AND-OR tree, and ack from
  // non-target slaves is masked off.
  assign slave_ack = |(s_ack_i & hit);

  always_comb begin
    slave_rdat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      slave_rdat = slave_rdat | s_rdat_gated[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    cnt_next   = cnt_reg;
    dat_next   = dat_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    mask_next  = mask_reg;
    int_next   = |(s_int_i & mask_reg);
    unique case (state_reg)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          cur_next = req_sel;
          cnt_next = '0;
          if ({1'b0, req_sel} < NUM_SLAVES_W) begin
            state_next = ACTIVE;
          end else if (req_sel == INT_ADDR) begin
            state_next = LOCAL;
          end else begin
            state_next = DONE;
            err_next   = 1'b1;
            dat_next   = '0;
          end
        end
      end
      ACTIVE: begin
        // Abort outranks a same-cycle ack: the master has already walked away.
        if (!m_cyc_i) begin
          state_next = IDLE;
        end else if (slave_ack) begin
          state_next = DONE;
          ack_next   = 1'b1;
          dat_next   = slave_rdat;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = DONE;
          err_next   = 1'b1;
          dat_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      LOCAL: begin
        state_next = DONE;
        if (offset == 24'd0) begin
          ack_next = 1'b1;
          dat_next = int_raw_w;
        end else if (offset == 24'd1) begin
          ack_next = 1'b1;
          dat_next = int_mask_w;
          if (m_we_i) begin
            mask_next[LW-1:0] = m_dat_i[LW-1:0];
          end
        end else begin
          err_next = 1'b1;
          dat_next = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cur_reg   <= '0;
      cnt_reg   <= '0;
      dat_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      int_reg   <= 1'b0;
      mask_reg  <= '1;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      cnt_reg   <= cnt_next;
      dat_reg   <= dat_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      int_reg   <= int_next;
      mask_reg  <= mask_next;
    end
  end

  assign m_dat_o = dat_reg;
  assign m_ack_o = ack_reg;
  assign m_err_o = err_reg;
  assign m_int_o = int_reg;

endmodule

// File: tb/tb_wishbone_interconnect_n.sv
// Randomized bench for wishbone_interconnect_n: each transaction's outcome, latency and data
// come from a transaction-level model, and the bench compares them with what the interconnect returns.
module tb_wishbone_interconnect_n;
  localparam int NS = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_we_i, m_cyc_i, m_stb_i;
  logic [3:0]        m_sel_i;
  logic [31:0]       m_adr_i, m_dat_i, m_dat_o;
  logic              m_ack_o, m_err_o, m_int_o;
  logic [NS-1:0]     s_we_o, s_cyc_o, s_stb_o;
  logic [4*NS-1:0]   s_sel_o;
  logic [32*NS-1:0]  s_adr_o, s_dat_o, s_dat_i;
  logic [NS-1:0]     s_ack_i, s_int_i;

  always #5 clk = ~clk;

  wishbone_interconnect_n #(
    .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO), .INT_ADDR(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_int_o(m_int_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_int_i(s_int_i)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_txn    = 0;
  logic [NS-1:0] mask_model;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: slave k acks in its d-th strobe cycle -> response d+1 cycles after the request,
  // unless TO strobe cycles pass first (err after TO+1). Local block answers after 2, unmapped after 1.
  task automatic run_txn(input logic [7:0] sel, input logic [23:0] off, input logic we,
                         input logic [31:0] wdat, input int ack_delay, input logic [31:0] rdat);
    logic          exp_ack, exp_err, chk_dat, seen;
    logic [31:0]   exp_dat;
    logic [3:0]    bsel;
    logic [NS-1:0] onehot;
    int            exp_lat, lat, stb_seen;
    chk_dat = 1'b1;
    onehot  = '0;
    if (int'(sel) < NS) begin
      onehot = NS'(1) << sel;
      if (ack_delay <= TO) begin
        exp_ack = 1'b1; exp_err = 1'b0; exp_dat = rdat; exp_lat = ack_delay + 1;
      end else begin
        exp_ack = 1'b0; exp_err = 1'b1; exp_dat = 32'h0; exp_lat = TO + 1;
      end
    end else if (sel == 8'hFF) begin
      exp_lat = 2;
      if (off == 24'd0) begin
        exp_ack = 1'b1; exp_err = 1'b0; exp_dat = 32'(s_int_i); chk_dat = !we;
      end else if (off == 24'd1) begin
        exp_ack = 1'b1; exp_err = 1'b0; exp_dat = 32'(mask_model); chk_dat = !we;
      end else begin
        exp_ack = 1'b0; exp_err = 1'b1; exp_dat = 32'h0;
      end
    end else begin
      exp_ack = 1'b0; exp_err = 1'b1; exp_dat = 32'h0; exp_lat = 1;
    end

    bsel    = 4'($urandom);
    s_dat_i = {$urandom, $urandom, $urandom, $urandom};
    if (int'(sel) < NS) s_dat_i[int'(sel)*32 +: 32] = rdat;
    s_ack_i = '0;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_sel_i = bsel;
    m_adr_i = {sel, off}; m_dat_i = wdat;

    seen = 1'b0; lat = 0; stb_seen = 0;
    while (!seen && lat < 40) begin
      tick;
      lat++;
      if (m_ack_o || m_err_o) begin
        seen = 1'b1;
      end else begin
        check_eq("stb_route", 32'(s_stb_o), 32'(onehot));
        check_eq("cyc_route", 32'(s_cyc_o), 32'(onehot));
        // Idle slaves ack randomly; the interconnect must ignore them.
        s_ack_i = NS'($urandom) & ~onehot;
        if (onehot != '0) begin
          check_eq("s_adr", s_adr_o[int'(sel)*32 +: 32], {8'h00, off});
          check_eq("s_dat", s_dat_o[int'(sel)*32 +: 32], wdat);
          check_eq("s_sel", 32'(s_sel_o[int'(sel)*4 +: 4]), 32'(bsel));
          check_eq("s_we", 32'(s_we_o), we ? 32'(onehot) : 32'h0);
          stb_seen++;
          if (stb_seen == ack_delay) s_ack_i = s_ack_i | onehot;
        end
      end
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
    check_eq("resp_seen", 32'(seen), 32'h1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("ack", 32'(m_ack_o), 32'(exp_ack));
    check_eq("err", 32'(m_err_o), 32'(exp_err));
    check_eq("stb_in_done", 32'(s_stb_o), 32'h0);
    if (chk_dat) check_eq("rdata", m_dat_o, exp_dat);
    $display("txn %0d sel=%02h off=%06h we=%0b ack=%0b err=%0b dat=%08h lat=%0d",
             n_txn, sel, off, we, m_ack_o, m_err_o, m_dat_o, lat);
    n_txn++;
    if (sel == 8'hFF && off == 24'd1 && we) mask_model = wdat[NS-1:0];
    tick;
    check_eq("resp_one_cycle", {30'h0, m_ack_o, m_err_o}, 32'h0);
    if (chk_dat) check_eq("dat_hold", m_dat_o, exp_dat);
  endtask

  task automatic set_int(input logic [NS-1:0] v);
    s_int_i = v;
    tick;
    check_eq("m_int", 32'(m_int_o), 32'(|(v & mask_model)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r_sel;
    logic [23:0] r_off;
    int          cat;
    rst = 1'b1;
    m_we_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_sel_i = '0;
    m_adr_i = '0; m_dat_i = '0; s_dat_i = '0; s_ack_i = '0; s_int_i = '0;
    mask_model = '1;
    repeat (3) tick;
    check_eq("rst_ack", 32'(m_ack_o), 32'h0);
    check_eq("rst_err", 32'(m_err_o), 32'h0);
    check_eq("rst_int", 32'(m_int_o), 32'h0);
    check_eq("rst_dat", m_dat_o, 32'h0);
    check_eq("rst_cyc", 32'(s_cyc_o), 32'h0);
    rst = 1'b0;
    tick;

    // Directed scenarios
    run_txn(8'h02, 24'h000010, 1'b0, 32'h0, 3, 32'hCAFEF00D);
    run_txn(8'hFF, 24'h000001, 1'b1, 32'h5, 0, 32'h0);
    set_int(4'b0011);
    run_txn(8'hFF, 24'h000001, 1'b0, 32'h0, 0, 32'h0);
    set_int(4'b0010);
    run_txn(8'h07, 24'h000000, 1'b0, 32'h0, 0, 32'h0);
    run_txn(8'h01, 24'h000000, 1'b0, 32'h0, 100, 32'h0);
    run_txn(8'h00, 24'h000004, 1'b1, 32'h12345678, 2, 32'h0BADBEEF);
    run_txn(8'hFF, 24'h000000, 1'b0, 32'h0, 0, 32'h0);
    run_txn(8'hFF, 24'h000002, 1'b0, 32'h0, 0, 32'h0);

    // Master abort two cycles into an access to slave 3
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h0300_0020;
    tick;
    check_eq("abort_stb1", 32'(s_stb_o), 32'h8);
    tick;
    check_eq("abort_stb2", 32'(s_stb_o), 32'h8);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    tick;
    check_eq("abort_cyc", 32'(s_cyc_o), 32'h0);
    check_eq("abort_resp", {30'h0, m_ack_o, m_err_o}, 32'h0);
    tick;
    check_eq("abort_resp2", {30'h0, m_ack_o, m_err_o}, 32'h0);
    $display("txn %0d abort to slave 3", n_txn);
    n_txn++;
    run_txn(8'h03, 24'h000008, 1'b0, 32'h0, 1, 32'h600DF00D);

    // Reset while ACTIVE with a same-cycle slave ack
    set_int(4'b1111);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h0000_0000;
    tick;
    s_dat_i[31:0] = 32'hA5A5A5A5;
    s_ack_i = 4'b0001;
    rst = 1'b1;
    tick;
    check_eq("mid_rst_ack", 32'(m_ack_o), 32'h0);
    check_eq("mid_rst_err", 32'(m_err_o), 32'h0);
    check_eq("mid_rst_stb", 32'(s_stb_o), 32'h0);
    check_eq("mid_rst_dat", m_dat_o, 32'h0);
    check_eq("mid_rst_int", 32'(m_int_o), 32'h0);
    $display("txn %0d reset during active", n_txn);
    n_txn++;
    rst = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
    mask_model = '1;
    tick;

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      cat = int'($urandom_range(0, 9));
      if (cat <= 5) begin
        r_sel = 8'($urandom_range(0, NS - 1));
        run_txn(r_sel, 24'($urandom), 1'($urandom), $urandom,
                int'($urandom_range(1, TO + 2)), $urandom);
      end else if (cat <= 7) begin
        r_off = ($urandom_range(0, 3) == 3) ? 24'($urandom_range(2, 24'hFFFFFF))
                                            : 24'($urandom_range(0, 1));
        run_txn(8'hFF, r_off, 1'($urandom), $urandom, 0, 32'h0);
      end else begin
        r_sel = 8'($urandom_range(NS, 254));
        run_txn(r_sel, 24'($urandom), 1'($urandom), $urandom, 0, 32'h0);
      end
      if ($urandom_range(0, 3) == 0) set_int(NS'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
